wb_xbar_shared: RTL and testbench
=================================

Name: wb_xbar_shared

Overview:
- Parametrised shared-bus WISHBONE interconnect. Connects NM masters to NS slaves through a single arbitrated bus.
- Successor to the fixed 3-master/3-slave TISC interconnect. Adds:
  - a parametrised address map;
  - registered round-robin arbitration with grant held for the whole cycle;
  - a default-slave error for unmapped addresses;
  - a watchdog that returns err when a slave does not respond;
  - a saturating timeout counter for debug.
- Sits between bus masters (PCI bridge, VIO, I2C controller, ...) and register or memory slaves.

Parameters:
- NM, 3, number of masters (1..8)
- NS, 3, number of slaves (1..8)
- AW, 21, address width
- DW, 32, data width
- SW, 4, select width (DW/8)
- SLV_BASE, {21'h100000,21'h000040,21'h000000}, NS*AW concatenated bases; slave k is at [k*AW +: AW]
- SLV_MASK, {21'h0FFFFF,21'h0FFFBF,21'h0FFFBF}, NS*AW concatenated masks; slave k matches when (adr & ~mask) == base
- TIMEOUT, 255, watchdog limit in cycles; 0 disables the watchdog

Ports:
- clk_i  in  1  bus clock
- rst_i  in  1  asynchronous, active-low reset
- m_cyc_i  in  NM  master cycle requests
- m_stb_i  in  NM  master strobes
- m_we_i  in  NM  master write enables
- m_adr_i  in  NM*AW  master addresses
- m_dat_i  in  NM*DW  master write data
- m_sel_i  in  NM*SW  master byte selects
- m_ack_o  out  NM  ack to masters
- m_err_o  out  NM  err to masters
- m_rty_o  out  NM  rty to masters
- m_dat_o  out  DW  read data, shared by all masters
- s_cyc_o  out  NS  slave cycle
- s_stb_o  out  NS  slave strobe
- s_we_o  out  NS  slave write enable
- s_adr_o  out  NS*AW  per-slave address (adr & mask)
- s_dat_o  out  DW  write data, shared by all slaves
- s_sel_o  out  SW  byte selects, shared by all slaves
- s_ack_i  in  NS  slave acks
- s_err_i  in  NS  slave errs
- s_rty_i  in  NS  slave rtys
- s_dat_i  in  NS*DW  slave read data
- gnt_o  out  NM  current one-hot grant (debug)
- timeout_cnt_o  out  8  saturating count of watchdog errors (debug)

Behaviour:
- Reset (rst_i low, asynchronous):
  - state=IDLE, grant=0, round-robin pointer=NM-1, watchdog=0, timeout_cnt_o=0.
  - All m_*_o and s_cyc/stb/we_o are 0.
- IDLE state:
  - If any m_cyc_i is high, at the next edge grant the first requester searching upward from pointer+1, with wrap-around. The pointer then takes that index, and state goes to BUSY.
  - If no m_cyc_i is high, remain in IDLE.
- BUSY state:
  - Grant is held while the granted master's m_cyc_i stays high. Other requests are ignored.
  - When the granted master's m_cyc_i is low at an edge: grant=0, state=IDLE.
  - This guarantees at least one idle cycle between tenures, so a master requesting on cycle 0 sees slave cyc on cycle 1 at the earliest.
- Bus mux and decode (combinational from the registered grant):
  - The granted master's adr/dat/sel/we/stb/cyc drive the internal bus.
  - Slave k is selected when (adr & ~mask_k) == base_k. If several slaves match, the lowest index wins.
  - Only the selected slave sees cyc/stb/we. s_adr_o[k] = adr & mask_k.
- Responses:
  - ack/err/rty and dat come from the selected slave and are routed only to the granted master. Non-granted masters see 0 on ack/err/rty.
  - m_dat_o is the selected slave's data, and 0 when no slave is selected.
- Unmapped address:
  - If granted stb is high and no slave is selected, m_err_o of the granted master is high in the same cycle (zero-wait).
  - No slave sees cyc or stb.
- Watchdog:
  - The counter increments each cycle that granted stb is high, a slave is selected, and the slave gives no ack/err/rty.
  - It clears on any slave response, when stb is low, or on grant change.
  - When the count equals TIMEOUT:
    - That cycle, m_err_o is asserted to the master.
    - s_cyc_o and s_stb_o are forced to 0 for that cycle, aborting the access.
    - The counter clears.
    - timeout_cnt_o increments, saturating at 255.
  - A slave response arriving in the same cycle as the timeout takes precedence: the slave's response is passed through and no timeout is counted.
  - TIMEOUT=0: the watchdog is disabled.
- Reset mid-transfer:
  - Grant and all strobes drop immediately (asynchronous).
  - After reset release, arbitration restarts from IDLE.

Test Plan:
- Reset and basic write:
  - Stimulus: release reset; master0 writes adr 21'h000004, dat 32'hDEADBEEF.
  - Required: s_cyc_o=3'b001 one cycle after m_cyc_i; s_adr_o[0]=21'h000004; m_ack_o=3'b001 follows slave ack in the same cycle.
- Round-robin arbitration:
  - Stimulus: masters 0, 1 and 2 all hold cyc continuously; each master does one access then drops cyc.
  - Required: grants come in the order 0,1,2,0, with exactly one idle cycle between grants; gnt_o is never multi-hot.
- Decode and read to slave 1:
  - Stimulus: master1 reads adr 21'h000044.
  - Required: s_stb_o=3'b010; s_adr_o[1]=21'h000004; m_dat_o equals slave1 data.
  - Stimulus: read adr 21'h100010.
  - Required: slave2 selected with s_adr_o[2]=21'h000010.
- Unmapped address:
  - Setup: SLV_BASE/MASK with slave2 removed (NS=2).
  - Stimulus: master0 strobes adr 21'h100000.
  - Required: m_err_o[0]=1 in the same cycle; s_cyc_o=0.
- Watchdog:
  - Setup: TIMEOUT=4; a slave never responds.
  - Required: m_err_o pulses 1 cycle after 4 stalled cycles; s_stb_o is 0 in that cycle; timeout_cnt_o=1.
  - Stimulus: repeat 300 times.
  - Required: timeout_cnt_o saturates at 255.
  - Stimulus: slave ack coincides with the TIMEOUT cycle.
  - Required: ack is passed through; no err; count unchanged.
- Reset mid-operation:
  - Stimulus: assert rst_i low while master2 is in BUSY.
  - Required: gnt_o=0 and s_cyc_o=0 immediately, without waiting for a clock edge.
  - Stimulus: release reset with master0 requesting.
  - Required: master0 is granted first (pointer=NM-1).

Source files
------------

// File: rtl/wb_xbar_shared_if.sv
// Bundle of the master-side and slave-side WISHBONE signals of the shared-bus interconnect.
// The xbar modport is the interconnect's view; master/slave are the views of the attached agents.
interface wb_xbar_shared_if #(
   parameter int NM = 3,
   parameter int NS = 3,
   parameter int AW = 21,
   parameter int DW = 32,
   parameter int SW = 4
);
   logic [NM-1:0]    m_cyc_i;
   logic [NM-1:0]    m_stb_i;
   logic [NM-1:0]    m_we_i;
   logic [NM*AW-1:0] m_adr_i;
   logic [NM*DW-1:0] m_dat_i;
   logic [NM*SW-1:0] m_sel_i;
   logic [NM-1:0]    m_ack_o;
   logic [NM-1:0]    m_err_o;
   logic [NM-1:0]    m_rty_o;
   logic [DW-1:0]    m_dat_o;

   logic [NS-1:0]    s_cyc_o;
   logic [NS-1:0]    s_stb_o;
   logic [NS-1:0]    s_we_o;
   logic [NS*AW-1:0] s_adr_o;
   logic [DW-1:0]    s_dat_o;
   logic [SW-1:0]    s_sel_o;
   logic [NS-1:0]    s_ack_i;
   logic [NS-1:0]    s_err_i;
   logic [NS-1:0]    s_rty_i;
   logic [NS*DW-1:0] s_dat_i;

   // Handshake: a transfer completes on the clock edge where the granted master's cyc and stb
   // are high together with exactly one of ack/err/rty; the master may only change its request
   // after that edge.
   modport xbar (
      input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
      output m_ack_o, m_err_o, m_rty_o, m_dat_o,
      output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
      input  s_ack_i, s_err_i, s_rty_i, s_dat_i
   );

   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
      input  m_ack_o, m_err_o, m_rty_o, m_dat_o
   );

   modport slave (
      input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
      output s_ack_i, s_err_i, s_rty_i, s_dat_i
   );
endinterface

// File: rtl/wb_xbar_shared.sv
// Shared-bus WISHBONE interconnect: NM masters, NS slaves, registered round-robin arbitration,
// address decode with default-slave error and a watchdog that aborts unanswered accesses.
module wb_xbar_shared #(
   parameter int NM = 3,
   parameter int NS = 3,
   parameter int AW = 21,
   parameter int DW = 32,
   parameter int SW = 4,
   parameter logic [NS*AW-1:0] SLV_BASE = {21'h100000, 21'h000040, 21'h000000},
   parameter logic [NS*AW-1:0] SLV_MASK = {21'h0FFFFF, 21'h0FFFBF, 21'h0FFFBF},
   parameter int TIMEOUT = 255
) (
   input  logic          clk_i,
   input  logic          rst_i,
   wb_xbar_shared_if.xbar bus,
   output logic [NM-1:0] gnt_o,
   output logic [7:0]    timeout_cnt_o,
   output logic          state_o
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam int PW = (NM > 1) ? $clog2(NM) : 1;
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   state_t        state_q, state_d;
   logic [NM-1:0] gnt_q, gnt_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [WW-1:0] wd_q, wd_d;
   logic [7:0]    tcnt_q, tcnt_d;

   logic          found;
   logic [PW-1:0] pick;

   logic          cyc, stb, we;
   logic [AW-1:0] adr;
   logic [DW-1:0] dat;
   logic [SW-1:0] bsel;

   logic [NS-1:0] slv;
   logic          slv_hit;
   logic [NS-1:0] slv_v;
   logic          req;
   logic          rsp_ack, rsp_err, rsp_rty, rsp_any;
   logic          unmapped;
   logic          wd_hit;
   logic [DW-1:0] rdat;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= PW'(NM - 1);
         wd_q    <= '0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         wd_q    <= wd_d;
         tcnt_q  <= tcnt_d;
      end
   end

   // Round-robin: first requester strictly above the pointer, else the lowest requester.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      found   = 1'b0;
      pick    = '0;
      for (int j = 0; j < NM; j++) begin
         if (!found && bus.m_cyc_i[j] && (j > int'(ptr_q))) begin
            found = 1'b1;
            pick  = PW'(j);
         end
      end
      for (int j = 0; j < NM; j++) begin
         if (!found && bus.m_cyc_i[j]) begin
            found = 1'b1;
            pick  = PW'(j);
         end
      end
      case (state_q)
         IDLE: begin
            if (found) begin
               for (int j = 0; j < NM; j++) gnt_d[j] = (PW'(j) == pick);
               ptr_d   = pick;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (!(|(gnt_q & bus.m_cyc_i))) begin
               gnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      cyc  = 1'b0;
      stb  = 1'b0;
      we   = 1'b0;
      adr  = '0;
      dat  = '0;
      bsel = '0;
      for (int i = 0; i < NM; i++) begin
         if (gnt_q[i]) begin
            cyc  = bus.m_cyc_i[i];
            stb  = bus.m_stb_i[i];
            we   = bus.m_we_i[i];
            adr  = bus.m_adr_i[i*AW +: AW];
            dat  = bus.m_dat_i[i*DW +: DW];
            bsel = bus.m_sel_i[i*SW +: SW];
         end
      end
   end

   // Lowest-index matching window wins when windows overlap.
   always_comb begin
      slv     = '0;
      slv_hit = 1'b0;
      for (int k = 0; k < NS; k++) begin
         if (!slv_hit && ((adr & ~SLV_MASK[k*AW +: AW]) == SLV_BASE[k*AW +: AW])) begin
            slv[k]  = 1'b1;
            slv_hit = 1'b1;
         end
      end
   end

   assign slv_v    = slv & {NS{cyc}};
   assign req      = cyc & stb;
   assign rsp_ack  = |(slv_v & bus.s_ack_i);
   assign rsp_err  = |(slv_v & bus.s_err_i);
   assign rsp_rty  = |(slv_v & bus.s_rty_i);
   assign rsp_any  = rsp_ack | rsp_err | rsp_rty;
   assign unmapped = req & ~slv_hit;
   // A real slave response in the limit cycle beats the timeout.
   assign wd_hit   = (TIMEOUT != 0) && req && slv_hit && !rsp_any && (wd_q == WW'(TIMEOUT));

   always_comb begin
      wd_d   = '0;
      tcnt_d = tcnt_q;
      if ((TIMEOUT != 0) && req && slv_hit && !rsp_any && !wd_hit && (gnt_d == gnt_q))
         wd_d = wd_q + WW'(1);
      if (wd_hit && (tcnt_q != 8'hFF))
         tcnt_d = tcnt_q + 8'd1;
   end

   always_comb begin
      rdat = '0;
      for (int k = 0; k < NS; k++) begin
         if (slv_v[k]) rdat = bus.s_dat_i[k*DW +: DW];
      end
   end

   assign bus.s_cyc_o = wd_hit ? '0 : slv_v;
   assign bus.s_stb_o = wd_hit ? '0 : (slv_v & {NS{stb}});
   assign bus.s_we_o  = slv_v & {NS{we}};
   assign bus.s_dat_o = dat;
   assign bus.s_sel_o = bsel;

   for (genvar k = 0; k < NS; k++) begin : g_sadr
      assign bus.s_adr_o[k*AW +: AW] = adr & SLV_MASK[k*AW +: AW];
   end

   assign bus.m_ack_o = gnt_q & {NM{rsp_ack}};
   assign bus.m_err_o = gnt_q & {NM{rsp_err | unmapped | wd_hit}};
   assign bus.m_rty_o = gnt_q & {NM{rsp_rty}};
   assign bus.m_dat_o = rdat;

   assign gnt_o         = gnt_q;
   assign timeout_cnt_o = tcnt_q;
   assign state_o       = (state_q == BUSY);

endmodule

// File: tb/tb_wb_xbar_shared.sv
// Directed bench for wb_xbar_shared: a vector table for decode/routing plus hand-written
// sequences for arbitration order, watchdog, unmapped access and asynchronous reset.
module tb_wb_xbar_shared;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   wb_xbar_shared_if #(.NM(3), .NS(3), .AW(21), .DW(32), .SW(4)) ia ();
   wb_xbar_shared_if #(.NM(3), .NS(2), .AW(21), .DW(32), .SW(4)) ib ();

   logic [2:0] gnt_a, gnt_b;
   logic [7:0] tcnt_a, tcnt_b;
   logic       st_a, st_b;

   wb_xbar_shared #(.TIMEOUT(4)) dut_a (
      .clk_i(clk), .rst_i(rst_n), .bus(ia),
      .gnt_o(gnt_a), .timeout_cnt_o(tcnt_a), .state_o(st_a)
   );

   wb_xbar_shared #(
      .NS(2),
      .SLV_BASE({21'h000040, 21'h000000}),
      .SLV_MASK({21'h0FFFBF, 21'h0FFFBF}),
      .TIMEOUT(0)
   ) dut_b (
      .clk_i(clk), .rst_i(rst_n), .bus(ib),
      .gnt_o(gnt_b), .timeout_cnt_o(tcnt_b), .state_o(st_b)
   );

   typedef struct {
      int          mst;
      logic [20:0] adr;
      logic        we;
      logic [31:0] wdat;
      logic [3:0]  bsel;
      int          slv;
      logic [2:0]  exp_sel;
      logic [20:0] exp_sadr;
      logic [31:0] exp_rdat;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ia.m_cyc_i = '0; ia.m_stb_i = '0; ia.m_we_i = '0;
      ia.m_adr_i = '0; ia.m_dat_i = '0; ia.m_sel_i = '0;
      ia.s_ack_i = '0; ia.s_err_i = '0; ia.s_rty_i = '0;
      ia.s_dat_i = {32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
      ib.m_cyc_i = '0; ib.m_stb_i = '0; ib.m_we_i = '0;
      ib.m_adr_i = '0; ib.m_dat_i = '0; ib.m_sel_i = '0;
      ib.s_ack_i = '0; ib.s_err_i = '0; ib.s_rty_i = '0;
      ib.s_dat_i = {32'h2222_0001, 32'h1111_0000};
   endtask

   task automatic apply_reset();
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input int n);
      logic [2:0] mbit;
      string      tag;
      mbit = 3'(1 << v.mst);
      tag  = $sformatf("vec%0d", n);
      step();
      ia.m_cyc_i[v.mst] = 1'b1;
      ia.m_stb_i[v.mst] = 1'b1;
      ia.m_we_i[v.mst]  = v.we;
      ia.m_adr_i[v.mst*21 +: 21] = v.adr;
      ia.m_dat_i[v.mst*32 +: 32] = v.wdat;
      ia.m_sel_i[v.mst*4 +: 4]   = v.bsel;
      @(negedge clk);
      check({tag, "_cyc_before_grant"}, ia.s_cyc_o, 3'b000);
      step();
      @(negedge clk);
      check({tag, "_gnt"}, gnt_a, mbit);
      check({tag, "_s_cyc"}, ia.s_cyc_o, v.exp_sel);
      check({tag, "_s_stb"}, ia.s_stb_o, v.exp_sel);
      check({tag, "_s_we"}, ia.s_we_o, v.we ? v.exp_sel : 3'b000);
      check({tag, "_s_adr"}, ia.s_adr_o[v.slv*21 +: 21], v.exp_sadr);
      check({tag, "_s_dat"}, ia.s_dat_o, v.wdat);
      check({tag, "_s_sel"}, ia.s_sel_o, v.bsel);
      check({tag, "_ack_before"}, ia.m_ack_o, 3'b000);
      ia.s_ack_i[v.slv] = 1'b1;
      #1;
      check({tag, "_m_ack"}, ia.m_ack_o, mbit);
      check({tag, "_m_err"}, ia.m_err_o, 3'b000);
      check({tag, "_m_dat"}, ia.m_dat_o, v.exp_rdat);
      step();
      ia.s_ack_i = '0;
      ia.m_cyc_i = '0;
      ia.m_stb_i = '0;
      ia.m_we_i  = '0;
      step();
   endtask

   initial begin
      int         order[4];
      int         zr[4];
      int         ntn, zrun, bad, gidx, errs;
      logic [2:0] prev_g, g, drop, prev_drop;

      vecs[0] = '{mst: 0, adr: 21'h000004, we: 1'b1, wdat: 32'hDEADBEEF, bsel: 4'hF,
                  slv: 0, exp_sel: 3'b001, exp_sadr: 21'h000004, exp_rdat: 32'h1111_0000};
      vecs[1] = '{mst: 1, adr: 21'h000044, we: 1'b0, wdat: 32'h0000_0000, bsel: 4'hF,
                  slv: 1, exp_sel: 3'b010, exp_sadr: 21'h000004, exp_rdat: 32'h2222_0001};
      vecs[2] = '{mst: 1, adr: 21'h100010, we: 1'b0, wdat: 32'h0000_0000, bsel: 4'hF,
                  slv: 2, exp_sel: 3'b100, exp_sadr: 21'h000010, exp_rdat: 32'h3333_0002};
      vecs[3] = '{mst: 2, adr: 21'h000080, we: 1'b1, wdat: 32'h1234_5678, bsel: 4'h3,
                  slv: 0, exp_sel: 3'b001, exp_sadr: 21'h000080, exp_rdat: 32'h1111_0000};
      vecs[4] = '{mst: 0, adr: 21'h1FFFFF, we: 1'b0, wdat: 32'h0000_0000, bsel: 4'hF,
                  slv: 2, exp_sel: 3'b100, exp_sadr: 21'h0FFFFF, exp_rdat: 32'h3333_0002};
      vecs[5] = '{mst: 2, adr: 21'h0000C0, we: 1'b0, wdat: 32'hCAFE_0000, bsel: 4'h1,
                  slv: 1, exp_sel: 3'b010, exp_sadr: 21'h000080, exp_rdat: 32'h2222_0001};

      clear_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_gnt", gnt_a, 3'b000);
      check("rst_tcnt", tcnt_a, 8'd0);
      check("rst_state", st_a, 1'b0);
      check("rst_s_cyc", ia.s_cyc_o, 3'b000);
      check("rst_m_resp", {ia.m_ack_o, ia.m_err_o, ia.m_rty_o}, 9'd0);
      rst_n = 1'b1;

      for (int n = 0; n < 6; n++) run_vec(vecs[n], n);

      // Round-robin with all three masters requesting; each re-requests one cycle after its tenure.
      apply_reset();
      step();
      ia.m_adr_i = '0;
      ia.s_ack_i = 3'b001;
      ia.m_cyc_i = 3'b111;
      ia.m_stb_i = 3'b111;
      for (int i = 0; i < 4; i++) begin order[i] = -1; zr[i] = -1; end
      ntn = 0; zrun = 0; bad = 0; prev_g = '0; prev_drop = '0;
      for (int c = 0; c < 60 && ntn < 4; c++) begin
         @(negedge clk);
         g = gnt_a;
         if (!$onehot0(g)) bad++;
         if (g != 3'b000 && prev_g != 3'b000 && g != prev_g) bad++;
         if (g == 3'b000) zrun++;
         else if (prev_g == 3'b000) begin
            gidx = -1;
            for (int i = 0; i < 3; i++) if (g[i]) gidx = i;
            order[ntn] = gidx;
            zr[ntn] = zrun;
            ntn++;
            zrun = 0;
         end
         prev_g = g;
         drop = ia.m_ack_o & g;
         step();
         ia.m_cyc_i = (ia.m_cyc_i & ~drop) | prev_drop;
         ia.m_stb_i = ia.m_cyc_i;
         prev_drop = drop;
      end
      check("rr_tenures", ntn, 4);
      check("rr_order0", order[0], 0);
      check("rr_order1", order[1], 1);
      check("rr_order2", order[2], 2);
      check("rr_order3", order[3], 0);
      check("rr_idle1", zr[1], 1);
      check("rr_idle2", zr[2], 1);
      check("rr_idle3", zr[3], 1);
      check("rr_multi_hot", bad, 0);
      step();
      clear_inputs();
      repeat (3) step();

      // Watchdog: slave ack lands exactly in the limit cycle.
      apply_reset();
      step();
      ia.m_cyc_i[0] = 1'b1;
      ia.m_stb_i[0] = 1'b1;
      step();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("wdc_stall%0d_err", c), ia.m_err_o, 3'b000);
         check($sformatf("wdc_stall%0d_stb", c), ia.s_stb_o, 3'b001);
         step();
      end
      ia.s_ack_i[0] = 1'b1;
      #1;
      check("wdc_ack", ia.m_ack_o, 3'b001);
      check("wdc_no_err", ia.m_err_o, 3'b000);
      check("wdc_stb_kept", ia.s_stb_o, 3'b001);
      step();
      ia.s_ack_i = '0;
      ia.m_cyc_i = '0;
      ia.m_stb_i = '0;
      @(negedge clk);
      check("wdc_tcnt", tcnt_a, 8'd0);
      step();

      // Watchdog: slave never answers.
      ia.m_cyc_i[0] = 1'b1;
      ia.m_stb_i[0] = 1'b1;
      step();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("wd_stall%0d_err", c), ia.m_err_o, 3'b000);
         step();
      end
      @(negedge clk);
      check("wd_err", ia.m_err_o, 3'b001);
      check("wd_stb_abort", ia.s_stb_o, 3'b000);
      check("wd_cyc_abort", ia.s_cyc_o, 3'b000);
      check("wd_no_ack", ia.m_ack_o, 3'b000);
      step();
      @(negedge clk);
      check("wd_tcnt1", tcnt_a, 8'd1);
      check("wd_stb_again", ia.s_stb_o, 3'b001);
      errs = 0;
      for (int c = 0; c < 1500; c++) begin
         if (ia.m_err_o[0]) errs++;
         @(negedge clk);
      end
      check("wd_err_pulses", errs, 300);
      check("wd_tcnt_sat", tcnt_a, 8'd255);
      step();
      clear_inputs();
      repeat (2) step();

      // Asynchronous reset while master2 holds the bus.
      apply_reset();
      step();
      ia.m_cyc_i[2] = 1'b1;
      ia.m_stb_i[2] = 1'b1;
      step();
      @(negedge clk);
      check("rmid_gnt_busy", gnt_a, 3'b100);
      check("rmid_cyc_busy", ia.s_cyc_o, 3'b001);
      #2;
      rst_n = 1'b0;
      #1;
      check("rmid_gnt_async", gnt_a, 3'b000);
      check("rmid_cyc_async", ia.s_cyc_o, 3'b000);
      check("rmid_stb_async", ia.s_stb_o, 3'b000);
      ia.m_cyc_i = 3'b111;
      ia.m_stb_i = 3'b111;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      @(negedge clk);
      check("rmid_first_gnt", gnt_a, 3'b001);
      step();
      clear_inputs();
      repeat (2) step();

      // Two-slave map: unmapped address gets a zero-wait error.
      apply_reset();
      step();
      ib.m_cyc_i[0] = 1'b1;
      ib.m_stb_i[0] = 1'b1;
      ib.m_adr_i[0 +: 21] = 21'h100000;
      @(negedge clk);
      check("unm_err_before_grant", ib.m_err_o, 3'b000);
      step();
      @(negedge clk);
      check("unm_err", ib.m_err_o, 3'b001);
      check("unm_s_cyc", ib.s_cyc_o, 2'b00);
      check("unm_s_stb", ib.s_stb_o, 2'b00);
      check("unm_ack", ib.m_ack_o, 3'b000);
      check("unm_dat", ib.m_dat_o, 32'h0);
      step();
      ib.m_cyc_i = '0;
      ib.m_stb_i = '0;
      step();

      // Watchdog disabled: a long stall never errors, then err/rty pass through.
      ib.m_cyc_i[1] = 1'b1;
      ib.m_stb_i[1] = 1'b1;
      ib.m_adr_i[21 +: 21] = 21'h000040;
      step();
      errs = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (ib.m_err_o != 3'b000) errs++;
      end
      check("wd_off_no_err", errs, 0);
      check("wd_off_stb", ib.s_stb_o, 2'b10);
      check("wd_off_tcnt", tcnt_b, 8'd0);
      ib.s_err_i[1] = 1'b1;
      #1;
      check("slv_err_pass", ib.m_err_o, 3'b010);
      check("slv_err_no_ack", ib.m_ack_o, 3'b000);
      ib.s_err_i[1] = 1'b0;
      ib.s_rty_i[1] = 1'b1;
      #1;
      check("slv_rty_pass", ib.m_rty_o, 3'b010);
      check("slv_rty_no_err", ib.m_err_o, 3'b000);
      step();
      clear_inputs();
      repeat (2) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
